mul_rr_arbiter: RTL and testbench

- Shares one W×W unsigned multiplier among NREQ requesters.
- Each requester presents an operand pair with valid/ready. The block picks one requester by round-robin and computes the product in a registered multiply stage. It then returns the product and the requester index on a single response channel with valid/ready.
- Sits between the sequencing FSMs of the datapath (the MAC/accumulate lanes) and the single physical multiplier, so that several lanes time-share it.

---
 rtl/mul_rr_arbiter_pkg.sv | 19 +
 rtl/mul_rr_arbiter_if.sv | 31 +++
 rtl/mul_rr_arbiter_rr_pick.sv | 44 ++++
 rtl/mul_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mul_rr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_rr_arbiter_pkg.sv
// Shared types, default widths and helpers for the round-robin multiplier arbiter.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int W_DEF     = 4;
    localparam int CNT_W_DEF = 16;

    // Requester index width; a single requester still needs one bit.
    function automatic int id_w(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/mul_rr_arbiter_if.sv
// Request and response channels between the datapath lanes and the shared multiplier.
interface mul_arb_if #(
    parameter int NREQ = mul_arb_pkg::NREQ_DEF,
    parameter int W    = mul_arb_pkg::W_DEF
) ();
    import mul_arb_pkg::*;

    localparam int ID_W = id_w(NREQ);

    // Valid/ready: a transfer happens on a rising edge where both are high. A source
    // holds valid and its payload stable until that edge; ready may depend on valid.
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [2*W-1:0]    rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/mul_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr, wrapping modulo NREQ.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_any_grant,
    output logic [ID_W-1:0] o_grant_idx,
    output logic [NREQ-1:0] o_grant
);

    logic [ID_W:0]   w_base;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_any_grant = 1'b0;
        o_grant_idx = '0;
        o_grant     = '0;
        w_sum       = '0;
        w_cand      = '0;
        // An out-of-range pointer restarts the scan at 0 so no index >= NREQ is ever produced.
        w_base = ({1'b0, i_ptr} >= (ID_W+1)'(NREQ)) ? '0 : {1'b0, i_ptr};
        // Scan farthest-first so the closest requester to the pointer wins the last write.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = w_base + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NREQ)) begin
                w_sum = w_sum - (ID_W+1)'(NREQ);
            end
            w_cand = w_sum[ID_W-1:0];
            if (i_req[w_cand]) begin
                o_any_grant = 1'b1;
                o_grant_idx = w_cand;
            end
        end
        if (o_any_grant) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_rr_arbiter.sv
// Time-shares one WxW unsigned multiplier among NREQ requesters with round-robin
// arbitration; one operation in flight, result returned with the requester index.
module mul_rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int  NREQ  = NREQ_DEF,
    parameter int  W     = W_DEF,
    parameter int  CNT_W = CNT_W_DEF,
    localparam int ID_W  = id_w(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    mul_arb_if.slave         bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output state_t           o_dbg_state,
    output logic [ID_W-1:0]  o_dbg_rr_ptr
);

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [2*W-1:0]   r_rsp_data;
    logic [CNT_W-1:0] r_op_count;

    logic             w_any;
    logic [ID_W-1:0]  w_idx;
    logic [NREQ-1:0]  w_grant;
    logic             w_accept;
    logic             w_done;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [ID_W-1:0]  w_ptr_nxt;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .o_any_grant (w_any),
        .o_grant_idx (w_idx),
        .o_grant     (w_grant)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept = 1'b1;
                    w_next   = MUL;
                end
            end
            MUL: w_next = RESP;
            RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand select driven by the one-hot grant keeps every slice base constant.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_a = w_a | bus.req_a[i*W +: W];
                w_b = w_b | bus.req_b[i*W +: W];
            end
        end
    end

    assign w_ptr_nxt = (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_op_count  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a  <= w_a;
                r_b  <= w_b;
                r_id <= w_idx;
            end
            if (r_state == MUL) begin
                r_rsp_data  <= {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            // Pointer moves only on completion, so fairness is measured in finished work.
            if (w_done) begin
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= w_ptr_nxt;
                r_op_count  <= r_op_count + 1'b1;
            end
        end
    end

    assign bus.req_ready = w_accept ? w_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign busy          = (r_state != IDLE);
    assign op_count      = r_op_count;
    assign o_dbg_state   = r_state;
    assign o_dbg_rr_ptr  = r_rr_ptr;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Randomised and directed bench for mul_rr_arbiter against a transaction-level model.
module tb_mul_rr_arbiter;
    import mul_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int W     = 4;
    localparam int CNT_W = 16;
    localparam int ID_W  = id_w(NREQ);

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    state_t           dbg_state;
    logic [ID_W-1:0]  dbg_rr_ptr;

    always #5 clk = ~clk;

    mul_arb_if #(.NREQ(NREQ), .W(W)) bus ();

    mul_rr_arbiter #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .op_count     (op_count),
        .o_dbg_state  (dbg_state),
        .o_dbg_rr_ptr (dbg_rr_ptr)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [ID_W+2*W-1:0] exp_q[$];
    int id_log[$];
    int data_log[$];
    int hs_cyc[$];
    int acc_cyc[$];
    int cyc = 0;
    bit chk_en = 1'b0;
    bit seen_valid = 1'b0;
    bit cont = 1'b0;
    logic [NREQ-1:0] last_grant = '0;

    int               m_ptr  = 0;
    logic [CNT_W-1:0] m_cnt  = '0;
    bit               m_pend = 1'b0;
    int               m_age  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Round-robin choice straight from the rule: first valid index from ptr, modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (((v >> ((ptr + k) % NREQ)) & NREQ'(1)) != '0) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- compare + model advance (negedge) ----------------
    always @(negedge clk) begin : monitor
        logic [NREQ-1:0]   exp_ready;
        logic [NREQ*W-1:0] sh;
        int g;
        int av;
        int bv;
        g = pick(bus.req_valid, m_ptr);
        exp_ready = (!m_pend && g >= 0) ? (NREQ'(1) << g) : '0;
        if (chk_en) begin
            chk("req_ready", bus.req_ready, exp_ready);
            chk("busy", busy, m_pend);
            chk("rsp_valid", bus.rsp_valid, m_pend && m_age >= 2);
            chk("op_count", op_count, m_cnt);
            chk("rr_ptr", dbg_rr_ptr, m_ptr);
            if (m_pend && m_age >= 2 && exp_q.size() > 0) begin
                chk("rsp_id", bus.rsp_id, exp_q[0][2*W +: ID_W]);
                chk("rsp_data", bus.rsp_data, exp_q[0][2*W-1:0]);
            end
        end
        if (!rst) begin
            if (|bus.req_ready) acc_cyc.push_back(cyc);
            if (bus.rsp_valid && bus.rsp_ready) begin
                id_log.push_back(int'(bus.rsp_id));
                data_log.push_back(int'(bus.rsp_data));
                hs_cyc.push_back(cyc);
            end
            if (bus.rsp_valid) seen_valid = 1'b1;
        end
        last_grant = rst ? '0 : bus.req_ready;
        if (rst) begin
            m_ptr  = 0;
            m_cnt  = '0;
            m_pend = 1'b0;
            m_age  = 0;
            exp_q.delete();
        end else if (!m_pend) begin
            if (g >= 0) begin
                sh = bus.req_a >> (g * W);
                av = int'(sh[W-1:0]);
                sh = bus.req_b >> (g * W);
                bv = int'(sh[W-1:0]);
                exp_q.push_back({ID_W'(g), (2*W)'(av * bv)});
                m_pend = 1'b1;
                m_age  = 1;
            end
        end else if (m_age >= 2) begin
            if (bus.rsp_ready) begin
                m_ptr = (int'(exp_q[0][2*W +: ID_W]) + 1) % NREQ;
                m_cnt = m_cnt + 1'b1;
                void'(exp_q.pop_front());
                m_pend = 1'b0;
            end
        end else begin
            m_age++;
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic post(input int i, input int a, input int b);
        bus.req_valid[i]     = 1'b1;
        bus.req_a[i*W +: W]  = W'(a);
        bus.req_b[i*W +: W]  = W'(b);
    endtask

    task automatic post_rand(input int i);
        post(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endtask

    // One clock; a requester granted on that edge drops valid (or re-posts in continuous mode).
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (last_grant[i]) begin
                if (cont) post_rand(i);
                else bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic clear_logs();
        id_log.delete();
        data_log.delete();
        hs_cyc.delete();
        acc_cyc.delete();
        seen_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (2) step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.rsp_ready = 1'b1;
        while ((busy || (|bus.req_valid)) && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 100, 1);
    endtask

    // ---------------- stimulus + literal expectations ----------------
    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        clear_logs();
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_op_count", op_count, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_rr_ptr", dbg_rr_ptr, 0);
        chk("reset_state", dbg_state, IDLE);

        // Single request, then max operands.
        bus.rsp_ready = 1'b1;
        post(0, 3, 5);
        repeat (6) step();
        chk("t1_count", id_log.size(), 1);
        chk("t1_id", at(id_log, 0), 0);
        chk("t1_data", at(data_log, 0), 15);
        chk("t1_latency", at(hs_cyc, 0) - at(acc_cyc, 0), 2);
        chk("t1_op_count", op_count, 1);
        post(2, 15, 15);
        repeat (6) step();
        chk("t2_id", at(id_log, 1), 2);
        chk("t2_data", at(data_log, 1), 225);
        chk("t2_op_count", op_count, 2);

        // All four requesting continuously from reset.
        do_reset();
        cont = 1'b1;
        for (int i = 0; i < NREQ; i++) post_rand(i);
        repeat (15) step();
        cont = 1'b0;
        chk("t3_op_count", op_count, 5);
        chk("t3_order0", at(id_log, 0), 0);
        chk("t3_order1", at(id_log, 1), 1);
        chk("t3_order2", at(id_log, 2), 2);
        chk("t3_order3", at(id_log, 3), 3);
        chk("t3_order4", at(id_log, 4), 0);
        for (int k = 0; k < 4; k++) chk("t3_interval", at(acc_cyc, k + 1) - at(acc_cyc, k), 3);
        drain();

        // Backpressure with requests pending.
        do_reset();
        bus.rsp_ready = 1'b0;
        post(1, 6, 7);
        post(3, 2, 9);
        repeat (2) step();
        for (int h = 0; h < 5; h++) begin
            #1;
            chk("t4_hold_valid", bus.rsp_valid, 1);
            chk("t4_hold_id", bus.rsp_id, 1);
            chk("t4_hold_data", bus.rsp_data, 42);
            chk("t4_hold_ready", bus.req_ready, 0);
            chk("t4_hold_busy", busy, 1);
            if (h == 1) post(0, 4, 4);
            step();
        end
        bus.rsp_ready = 1'b1;
        repeat (12) step();
        chk("t4_order0", at(id_log, 0), 1);
        chk("t4_order1", at(id_log, 1), 3);
        chk("t4_order2", at(id_log, 2), 0);
        chk("t4_data1", at(data_log, 1), 18);
        chk("t4_data2", at(data_log, 2), 16);

        // Pointer wrap past the last requester.
        do_reset();
        post(3, 1, 1);
        step();
        post(0, 2, 3);
        post(2, 5, 5);
        repeat (10) step();
        chk("t5_order0", at(id_log, 0), 3);
        chk("t5_order1", at(id_log, 1), 0);
        chk("t5_order2", at(id_log, 2), 2);
        chk("t5_data1", at(data_log, 1), 6);
        chk("t5_data2", at(data_log, 2), 25);

        // Reset while the multiply is in flight.
        do_reset();
        post(1, 7, 7);
        step();
        #1;
        chk("t6_in_mul", dbg_state, MUL);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_rsp_valid", bus.rsp_valid, 0);
        chk("t6_op_count", op_count, 0);
        chk("t6_rr_ptr", dbg_rr_ptr, 0);
        chk("t6_busy", busy, 0);
        chk("t6_no_response", seen_valid, 0);
        post(0, 1, 2);
        post(1, 3, 3);
        repeat (10) step();
        chk("t6_count", id_log.size(), 2);
        chk("t6_order0", at(id_log, 0), 0);
        chk("t6_order1", at(id_log, 1), 1);

        // Random traffic, backpressure and occasional reset.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) post_rand(i);
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
